alu_multicycle: RTL
===================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits, legal range 8..64.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-low.
REQ-004 in_valid_i  input  1  operation request valid.
REQ-005 in_ready_o  output  1  block can accept a request.
REQ-006 src1_i  input  WIDTH  operand A.
REQ-007 src2_i  input  WIDTH  operand B.
REQ-008 ctrl_i  input  4  operation select.
REQ-009 out_valid_o  output  1  result valid.
REQ-010 out_ready_i  input  1  consumer accepts result.
REQ-011 result_o  output  WIDTH  result, low word for MUL.
REQ-012 result_hi_o  output  WIDTH  MUL high word; 0 for all other ops.
REQ-013 zero_o  output  1  result_o == 0.
REQ-014 ovf_o  output  1  signed overflow, ADD/SUB only; else 0.
REQ-015 dz_o  output  1  divide by zero, DIVU/REMU only; else 0.

Function
REQ-016 Request accepted on rising edge with in_valid_i && in_ready_o; src1_i, src2_i, ctrl_i captured then; later input changes SHALL NOT affect the operation.
REQ-017 ctrl_i decode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLTU (unsigned A<B ? 1:0), 1000 SLT (signed), 1011 MUL (unsigned, 2*WIDTH product), 1100 EQ (A==B ? 1:0), 1101 DIVU quotient, 1110 REMU remainder; other codes -> result 0, all flags 0, single-cycle latency.
REQ-018 ADD/SUB wrap modulo 2^WIDTH; ovf_o = operand signs agree (ADD) / differ (SUB) and result sign differs from A.
REQ-019 FSM states IDLE, MUL, DIV, DONE; in_ready_o = 1 only in IDLE.
REQ-020 IDLE: on accept, single-cycle ops -> DONE; MUL -> MUL; DIVU/REMU -> DIV (or DONE if B==0, REQ-023).
REQ-021 MUL: shift-add, one operand bit per cycle, exactly WIDTH cycles, then DONE; out_valid_o asserts WIDTH+1 cycles after accept edge.
REQ-022 DIV: restoring shift-subtract, one quotient bit per cycle, exactly WIDTH cycles, then DONE; out_valid_o asserts WIDTH+1 cycles after accept edge.
REQ-023 B==0 for DIVU/REMU: no iteration; DONE next cycle; quotient all ones, remainder = A, dz_o = 1.
REQ-024 Single-cycle ops: out_valid_o asserts the cycle after accept edge.
REQ-025 DONE: out_valid_o = 1; result_o, result_hi_o, zero_o, ovf_o, dz_o held stable until out_ready_i sampled high; then -> IDLE, out_valid_o = 0 next cycle.
REQ-026 out_valid_o SHALL be 0 in IDLE, MUL and DIV; outputs registered, no combinational path from inputs to outputs.
REQ-027 in_valid_i while in_ready_o = 0 SHALL be ignored (not queued).
REQ-028 Iteration counter width ceil(log2(WIDTH+1)); SHALL not wrap before WIDTH cycles complete.

Reset
REQ-029 rst_i low SHALL immediately (asynchronously) force state IDLE, in_ready_o 1 after release edge, out_valid_o 0, result_o 0, result_hi_o 0, zero_o 0, ovf_o 0, dz_o 0, counter 0.
REQ-030 Reset asserted mid-MUL/DIV or in DONE SHALL abort the operation; no result delivered for it.
REQ-031 First request after release accepted on first rising edge with rst_i high and in_valid_i high.

Verification (WIDTH=32)
REQ-032 ADD 0x7FFFFFFF+0x00000001 -> result_o 0x80000000, ovf_o 1, zero_o 0, out_valid_o 1 cycle after accept.
REQ-033 MUL 0xFFFFFFFF*0xFFFFFFFF -> result_hi_o 0xFFFFFFFE, result_o 0x00000001, out_valid_o exactly 33 cycles after accept.
REQ-034 DIVU 100/7 -> 0x0000000E; REMU 100/7 -> 0x00000002; DIVU 7/0 -> 0xFFFFFFFF, dz_o 1, latency 1; REMU 7/0 -> 0x00000007, dz_o 1.
REQ-035 SLT 0xFFFFFFFF vs 0x00000001 -> 1; SLTU same operands -> 0; EQ 5 vs 5 -> 1, zero_o 0; SUB 5-5 -> 0, zero_o 1.
REQ-036 Backpressure: out_ready_i low 5 cycles in DONE -> outputs unchanged, in_ready_o 0, concurrent in_valid_i ignored; out_ready_i high -> IDLE next cycle.
REQ-037 rst_i low at cycle 10 of MUL -> out_valid_o 0 immediately; after release, AND 0xF0F0F0F0&0x0FF00FF0 -> 0x00F000F0 with latency 1.

Source files
------------

// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked ALU; single-cycle logic/compare/add ops,
// iterative shift-add multiply and restoring divide sharing one datapath.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic             zero_o,
    output logic             ovf_o,
    output logic             dz_o
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1011;
    localparam logic [3:0] OP_EQ   = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1101;
    localparam logic [3:0] OP_REMU = 4'b1110;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi, lo, opnd;
    logic             is_rem;
    logic [WIDTH-1:0] sum, dif, sc_res;
    logic             sc_ovf, sc_dz, is_div, last;
    logic [WIDTH:0]   mul_sum, div_sh, div_dif;
    logic [WIDTH-1:0] mul_hi, mul_lo, div_rem, div_quo, div_res;

    assign in_ready_o  = state == IDLE;
    assign out_valid_o = state == DONE;
    assign last        = cnt == CW'(WIDTH - 1);
    assign is_div      = ctrl_i == OP_DIVU || ctrl_i == OP_REMU;
    assign sum         = src1_i + src2_i;
    assign dif         = src1_i - src2_i;

    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        sc_dz  = 1'b0;
        case (ctrl_i)
            OP_AND:  sc_res = src1_i & src2_i;
            OP_OR:   sc_res = src1_i | src2_i;
            OP_ADD: begin
                sc_res = sum;
                sc_ovf = src1_i[WIDTH-1] == src2_i[WIDTH-1] && sum[WIDTH-1] != src1_i[WIDTH-1];
            end
            OP_SUB: begin
                sc_res = dif;
                sc_ovf = src1_i[WIDTH-1] != src2_i[WIDTH-1] && dif[WIDTH-1] != src1_i[WIDTH-1];
            end
            OP_SLTU: sc_res = WIDTH'(src1_i < src2_i);
            OP_SLT:  sc_res = WIDTH'($signed(src1_i) < $signed(src2_i));
            OP_EQ:   sc_res = WIDTH'(src1_i == src2_i);
            OP_DIVU: begin
                sc_res = '1;
                sc_dz  = 1'b1;
            end
            OP_REMU: begin
                sc_res = src1_i;
                sc_dz  = 1'b1;
            end
            default: sc_res = '0;
        endcase
    end

    // MUL: hi:lo is the partial product with the multiplier shifting out of lo.
    // DIV: hi is the partial remainder, lo shifts the dividend out and quotient bits in.
    assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], lo[WIDTH-1:1]};
    assign div_sh  = {hi, lo[WIDTH-1]};
    assign div_dif = div_sh - {1'b0, opnd};
    assign div_rem = div_dif[WIDTH] ? div_sh[WIDTH-1:0] : div_dif[WIDTH-1:0];
    assign div_quo = {lo[WIDTH-2:0], ~div_dif[WIDTH]};
    assign div_res = is_rem ? div_rem : div_quo;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            opnd        <= '0;
            is_rem      <= 1'b0;
            result_o    <= '0;
            result_hi_o <= '0;
            zero_o      <= 1'b0;
            ovf_o       <= 1'b0;
            dz_o        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid_i) begin
                    cnt <= '0;
                    if (ctrl_i == OP_MUL) begin
                        hi    <= '0;
                        lo    <= src2_i;
                        opnd  <= src1_i;
                        state <= MUL;
                    end else if (is_div && src2_i != '0) begin
                        hi     <= '0;
                        lo     <= src1_i;
                        opnd   <= src2_i;
                        is_rem <= ctrl_i == OP_REMU;
                        state  <= DIV;
                    end else begin
                        result_o    <= sc_res;
                        result_hi_o <= '0;
                        zero_o      <= sc_res == '0;
                        ovf_o       <= sc_ovf;
                        dz_o        <= sc_dz;
                        state       <= DONE;
                    end
                end
                MUL: begin
                    hi  <= mul_hi;
                    lo  <= mul_lo;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        result_o    <= mul_lo;
                        result_hi_o <= mul_hi;
                        zero_o      <= mul_lo == '0;
                        ovf_o       <= 1'b0;
                        dz_o        <= 1'b0;
                        state       <= DONE;
                    end
                end
                DIV: begin
                    hi  <= div_rem;
                    lo  <= div_quo;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        result_o    <= div_res;
                        result_hi_o <= '0;
                        zero_o      <= div_res == '0;
                        ovf_o       <= 1'b0;
                        dz_o        <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: if (out_ready_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
